// File: rtl/csel_pkg.sv
// Shared definitions for the carry-select subtractor slice.
//
// Contents:
//   DEF_WIDTH   - default operand/result width
//   DEF_CHUNK   - default bits resolved per pipeline stage
//   stages()    - number of pipeline stages (also the latency) for a width/chunk pair
//   chunk_res_t - one resolved chunk: carry out plus sum bits
package csel_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef struct packed {
        logic                 carry;
        logic [DEF_CHUNK-1:0] sum;
    } chunk_res_t;

    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/csel_chunk.sv
// Combinational CHUNK-bit carry-select adder slice.
// Both carry-in cases are precomputed and csel picks one, so the slice's
// critical path from csel is only the final mux.
//
// Ports:
//   x, y  - CHUNK-bit addends
//   csel  - carry-in that selects between the two precomputed results
//   sum   - selected CHUNK-bit sum
//   cout  - selected carry out
module csel_chunk
    import csel_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             csel,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] res0;
    logic [CHUNK:0] res1;

    always_comb begin
        res0 = {1'b0, x} + {1'b0, y};
        res1 = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, 1'b1};
        {cout, sum} = csel ? res1 : res0;
    end

endmodule

// File: rtl/csel_pipe_subtractor.sv
// Pipelined carry-select subtractor: diff = a - b - bin (mod 2^WIDTH).
// Computed as a + ~b + ~bin, one CHUNK-bit slice per stage. Each stage holds
// a valid bit, the carry out of its slice, the result chunks resolved so far,
// the still-pending upper chunks of a and ~b, and the two operand sign bits.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid, in_ready    - operand handshake
//   a, b, bin             - minuend, subtrahend, borrow-in
//   out_valid, out_ready  - result handshake
//   diff                  - a - b - bin modulo 2^WIDTH
//   borrow_out            - 1 when a < b + bin (unsigned)
//   overflow              - signed overflow of the subtraction
//
// Handshake: a beat transfers on a rising edge where valid && ready. The
// pipe advances as a whole only when the output slot is empty or being
// drained (adv = !out_valid || out_ready); in_ready equals adv, so while the
// consumer stalls nothing moves and the output stays stable. A cycle with
// adv and no input beat shifts a bubble into stage 0.
module csel_pipe_subtractor
    import csel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int STAGES = stages(WIDTH, CHUNK);
    // Pending operand bits shrink by one chunk per stage and resolved result
    // bits grow by one chunk, so both are packed as triangles into flat
    // vectors: stage i owns pending bits at PEND offset i*WIDTH - CHUNK*i*(i+1)/2
    // and result bits at RES offset CHUNK*i*(i+1)/2.
    localparam int PEND_BITS = (STAGES - 1) * WIDTH - (CHUNK * (STAGES - 1) * STAGES) / 2;
    localparam int RES_BITS  = (CHUNK * STAGES * (STAGES + 1)) / 2;
    localparam int RES_LAST  = (CHUNK * (STAGES - 1) * STAGES) / 2;

    logic                 adv;
    logic [STAGES-1:0]    vld_q, vld_d;
    logic [STAGES-1:0]    cry_q, cry_d;
    logic [STAGES-1:0]    sa_q, sa_d;
    logic [STAGES-1:0]    sb_q, sb_d;
    logic [PEND_BITS-1:0] a_pend_q, a_pend_d;
    logic [PEND_BITS-1:0] nb_pend_q, nb_pend_d;
    logic [RES_BITS-1:0]  res_q, res_d;

    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int ROFF = (CHUNK * i * (i + 1)) / 2;

        logic [CHUNK-1:0] x;
        logic [CHUNK-1:0] y;
        logic [CHUNK-1:0] s;
        logic             ci;

        csel_chunk #(.CHUNK(CHUNK)) u_chunk (
            .x    (x),
            .y    (y),
            .csel (ci),
            .sum  (s),
            .cout (cry_d[i])
        );

        if (i == 0) begin : g_head
            // Borrow-in becomes an inverted carry-in to the lowest slice.
            assign x                    = a[CHUNK-1:0];
            assign y                    = ~b[CHUNK-1:0];
            assign ci                   = ~bin;
            assign vld_d[0]             = in_valid;
            assign sa_d[0]              = a[WIDTH-1];
            assign sb_d[0]              = b[WIDTH-1];
            assign res_d[ROFF +: CHUNK] = s;
        end else begin : g_body
            localparam int PPREV = (i - 1) * WIDTH - (CHUNK * (i - 1) * i) / 2;
            localparam int RPREV = (CHUNK * (i - 1) * i) / 2;

            assign x        = a_pend_q[PPREV +: CHUNK];
            assign y        = nb_pend_q[PPREV +: CHUNK];
            assign ci       = cry_q[i-1];
            assign vld_d[i] = vld_q[i-1];
            assign sa_d[i]  = sa_q[i-1];
            assign sb_d[i]  = sb_q[i-1];
            assign res_d[ROFF +: (i + 1) * CHUNK] = {s, res_q[RPREV +: i * CHUNK]};
        end

        if (i < STAGES - 1) begin : g_pend
            localparam int HI   = WIDTH - (i + 1) * CHUNK;
            localparam int POFF = i * WIDTH - (CHUNK * i * (i + 1)) / 2;

            if (i == 0) begin : g_load
                assign a_pend_d[POFF +: HI]  = a[WIDTH-1:CHUNK];
                assign nb_pend_d[POFF +: HI] = ~b[WIDTH-1:CHUNK];
            end else begin : g_shift
                // Drop the chunk this stage just consumed.
                localparam int PPREV = (i - 1) * WIDTH - (CHUNK * (i - 1) * i) / 2;
                assign a_pend_d[POFF +: HI]  = a_pend_q[PPREV + CHUNK +: HI];
                assign nb_pend_d[POFF +: HI] = nb_pend_q[PPREV + CHUNK +: HI];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            cry_q     <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            a_pend_q  <= '0;
            nb_pend_q <= '0;
            res_q     <= '0;
        end else if (adv) begin
            vld_q     <= vld_d;
            cry_q     <= cry_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            a_pend_q  <= a_pend_d;
            nb_pend_q <= nb_pend_d;
            res_q     <= res_d;
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign diff       = res_q[RES_LAST +: WIDTH];
    // Gated by valid so the reset state (carry = 0) reads as no borrow.
    assign borrow_out = vld_q[STAGES-1] & ~cry_q[STAGES-1];
    assign overflow   = (sa_q[STAGES-1] != sb_q[STAGES-1]) && (diff[WIDTH-1] != sa_q[STAGES-1]);

endmodule

// File: tb/tb_csel_pipe_subtractor.sv
module tb_csel_pipe_subtractor;

    localparam int W  = 16;
    localparam int EW = W + 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic          borrow_out;
    logic          overflow;

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    csel_pipe_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain 17-bit unsigned subtraction.
    function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic bv_in);
        logic [W:0]   full;
        logic [W-1:0] d;
        logic         ov;
        full = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bv_in};
        d    = full[W-1:0];
        ov   = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
        return {d, full[W], ov};
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                         input logic [EW-1:0] expv);
        int budget = 50;
        @(negedge clk);
        a = av; b = bv; bin = bv_in; in_valid = 1'b1;
        #1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed low, required 1");
        end else begin
            exp_q.push_back(expv);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen.
    task automatic measure_latency(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!out_valid && k < 20);
        check(name, k, 4);
    endtask

    task automatic wait_empty(input string name);
        int budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got diff=%h with no beat outstanding, required none", diff);
                end else begin
                    check("out_beat", {14'd0, diff, borrow_out, overflow}, {14'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0]  ra[6];
    logic [W-1:0]  rb[6];
    logic          rbin[6];
    logic [EW-1:0] held;
    bit            stalled;
    int            sent;
    int            cyc;
    int            stale;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", {out_valid, in_ready, diff, borrow_out, overflow}, {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        // Basic subtraction and latency from an idle pipe.
        issue(16'h1234, 16'h0234, 1'b0, {16'h1000, 1'b0, 1'b0});
        measure_latency("latency_basic");

        // Directed corner vectors back to back (one beat per cycle).
        issue(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0});
        issue(16'h0005, 16'h0003, 1'b1, {16'h0001, 1'b0, 1'b0});
        issue(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1});
        issue(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1});
        issue(16'h1000, 16'h0001, 1'b0, {16'h0FFF, 1'b0, 1'b0});
        issue(16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFF, 1'b1, 1'b0});
        issue(16'h0000, 16'h0000, 1'b1, {16'hFFFF, 1'b1, 1'b0});
        wait_empty("drain_directed");

        // Streaming with a consumer stall in cycles 5..7 after the first beat.
        for (int i = 0; i < 6; i++) begin
            ra[i]   = W'($urandom_range(0, 16'hFFFF));
            rb[i]   = W'($urandom_range(0, 16'hFFFF));
            rbin[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; cyc = 0; stalled = 1'b0; held = '0;
        while ((sent < 6 || exp_q.size() != 0) && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (sent < 6) begin
                a = ra[sent]; b = rb[sent]; bin = rbin[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                if (!stalled) begin
                    held    = {diff, borrow_out, overflow};
                    stalled = 1'b1;
                end else begin
                    check("stall_hold", {14'd0, diff, borrow_out, overflow}, {14'd0, held});
                end
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ra[sent], rb[sent], rbin[sent]));
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_done", {31'd0, cyc < 60}, 32'd1);
        check("stall_seen", {31'd0, stalled}, 32'd1);

        // Reset while three beats are in flight and the output is stalled.
        @(negedge clk);
        out_ready = 1'b0;
        issue(16'h00FF, 16'h000F, 1'b0, {16'h00F0, 1'b0, 1'b0});
        issue(16'h0A0A, 16'h0101, 1'b0, {16'h0909, 1'b0, 1'b0});
        issue(16'h2000, 16'h1000, 1'b0, {16'h1000, 1'b0, 1'b0});
        stale = 0;
        while (!out_valid && stale < 20) begin
            @(negedge clk);
            #1;
            stale++;
        end
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset", {out_valid, in_ready, diff, borrow_out, overflow}, {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0});
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("no_stale_after_reset", stale, 0);

        issue(16'h4321, 16'h1111, 1'b0, {16'h3210, 1'b0, 1'b0});
        measure_latency("latency_post_reset");
        wait_empty("drain_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csel_pipe_subtractor.md
Name: csel_pipe_subtractor

Overview:
- Pipelined, carry-select subtractor computing D = A - B - Bin on WIDTH-bit unsigned/two's-complement operands.
- Works one CHUNK-bit slice per pipeline stage; each stage precomputes both carry cases and selects using the registered carry from the stage below.
- Sits beside the 16-bit carry-select adder in the datapath. Adds valid/ready handshakes so it can feed stalling consumers.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per stage.
- STAGES = WIDTH/CHUNK (4), derived local constant; it is also the pipeline latency.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  A - B - Bin, taken modulo 2^WIDTH.
- borrow_out  out  1  1 when A < B + Bin (unsigned).
- overflow  out  1  signed overflow of the subtraction.

Behaviour:
- Arithmetic is implemented as A + ~B + ~bin.
  - Carry-in to chunk 0 is ~bin.
  - borrow_out is the inverse of the carry out of the top chunk.
  - overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the original operands, which are carried down the pipe.
- Per stage i, for chunk slice [i*CHUNK +: CHUNK]:
  - Compute sum0/carry0 (carry-in 0) and sum1/carry1 (carry-in 1).
  - Select both with the carry registered by stage i-1. Stage 0 uses ~bin directly.
- Operand skew:
  - Upper chunks of ~B and A are delay-registered, so each chunk arrives at its stage in the same cycle as its carry.
  - Lower result chunks are delay-registered, so all chunks align at the output.
- Stage register contents: valid bit, carry, resolved low chunks, pending high operand chunks, and the two sign bits.
- Advance enable: adv = !out_valid || out_ready. The whole pipe shifts only when adv = 1 (global stall, no bubbles collapsed).
- Handshake rules:
  - in_ready = adv.
  - A beat is accepted iff in_valid && in_ready.
  - When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Latency: a beat accepted in cycle N appears with out_valid = 1 in cycle N+STAGES, provided there are no stalls. Throughput is one result per cycle.
- Output hold: while out_valid && !out_ready, diff, borrow_out and overflow stay stable, and no stage register changes.
- Output hold: out_valid is never dropped without a handshake.
- Reset, asserted at any time including mid-stream:
  - All valid bits clear immediately; in-flight beats are discarded.
  - out_valid = 0; diff = 0, borrow_out = 0, overflow = 0; internal carries = 0.
  - in_ready = 1 during and after reset, because out_valid = 0.
- Simultaneous events: output handshake and input acceptance in the same cycle is legal and required for full throughput.
- Wrap-around: results are taken modulo 2^WIDTH. 0 - 1 gives all-ones with borrow_out = 1.

Decomposition:
- Package csel_pkg contains:
  - localparams DEF_WIDTH = 16 and DEF_CHUNK = 4.
  - Function stages(width, chunk), which returns width/chunk.
  - A typedef for the chunk-result struct {carry, sum}.
- Sub-module csel_chunk: combinational CHUNK-bit dual-carry adder plus select mux.
  - Inputs: x, y, csel.
  - Outputs: sum, cout.
  - Instantiated once per stage via generate.
- The top module holds only the skew/delay registers, the valid pipe and the handshake logic.

Test Plan:
- Basic subtraction: a=0x1234, b=0x0234, bin=0, out_ready=1 -> 4 cycles later diff=0x1000, borrow_out=0, overflow=0.
- Unsigned wrap: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, borrow_out=1, overflow=0. Also a=0x0005, b=0x0003, bin=1 -> diff=0x0001, borrow_out=0.
- Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, overflow=1, borrow_out=0. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, overflow=1, borrow_out=1.
- Cross-chunk borrow ripple: a=0x1000, b=0x0001 -> diff=0x0FFF. This propagates a borrow across all four stages.
- Streaming with backpressure:
  - Send 6 back-to-back beats with random operands.
  - Hold out_ready=0 for cycles 5-7 after the first beat.
  - Expected: in_ready=0 and outputs frozen during the stall; all 6 results arrive in order, none lost or duplicated, each matching the reference model.
- Reset mid-stream: assert rst while 3 beats are in flight -> out_valid=0 and diff=0 immediately (asynchronously). No stale beat emerges after reset is released. The first post-reset beat appears after 4 cycles.
